// File: rtl/param_wb_cache.sv
// param_wb_cache: set-associative, write-back / write-allocate cache with true-LRU
// replacement, talking to main memory one word per RAM_ready handshake.
module param_wb_cache #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned WAYS   = 4,
   parameter int unsigned SETS   = 64,
   parameter int unsigned WORDS  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              search_cache,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic              hit,
   output logic              data_ready,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic [ADDR_W-1:0] RAM_address,
   output logic              RAM_read,
   output logic              RAM_write,
   output logic [DATA_W-1:0] RAM_wdata,
   input  logic [DATA_W-1:0] main_memory_data,
   input  logic              RAM_ready
);
   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);
   localparam logic [WAY_W-1:0] LRU_AGE   = WAY_W'(WAYS - 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

   // line storage, flat-indexed as {set, way, word} and {set, way}
   logic [DATA_W-1:0] data_mem [SETS*WAYS*WORDS];
   logic [TAG_W-1:0]  tag_mem  [SETS*WAYS];
   logic [WAYS-1:0]   valid_mem [SETS];
   logic [WAYS-1:0]   dirty_mem [SETS];
   logic [WAY_W-1:0]  age_mem  [SETS][WAYS];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic              req_we_q, req_we_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic              lookup_hit_q, lookup_hit_d;
   logic [WAY_W-1:0]  way_q, way_d;
   logic [OFF_W-1:0]  word_q, word_d;
   logic              hit_q, hit_d;
   logic              data_ready_q, data_ready_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_read_q, ram_read_d;
   logic              ram_write_q, ram_write_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_set;
   logic [OFF_W-1:0]  req_word;
   logic              lookup_hit, inv_found;
   logic [WAY_W-1:0]  hit_way, inv_way, lru_victim, victim_way, lru_way;
   logic [OFF_W-1:0]  word_nxt;
   logic              lru_en, fill_en, set_dirty;

   assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
   assign req_set  = req_addr_q[OFF_W +: IDX_W];
   assign req_word = req_addr_q[OFF_W-1:0];
   assign word_nxt = word_q + OFF_W'(1);

   always_comb begin
      lookup_hit = 1'b0;
      hit_way    = '0;
      inv_found  = 1'b0;
      inv_way    = '0;
      lru_victim = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_mem[req_set][WAY_W'(w)] && tag_mem[{req_set, WAY_W'(w)}] == req_tag) begin
            lookup_hit = 1'b1;
            hit_way    = WAY_W'(w);
         end
         if (age_mem[req_set][WAY_W'(w)] == LRU_AGE) lru_victim = WAY_W'(w);
      end
      // descending scan so the lowest-index invalid way wins
      for (int unsigned w = WAYS; w > 0; w--) begin
         if (!valid_mem[req_set][WAY_W'(w - 1)]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w - 1);
         end
      end
      victim_way = inv_found ? inv_way : lru_victim;
   end

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      req_we_d     = req_we_q;
      req_wdata_d  = req_wdata_q;
      lookup_hit_d = lookup_hit_q;
      way_d        = way_q;
      word_d       = word_q;
      hit_d        = hit_q;
      data_ready_d = 1'b0;
      data_d       = data_q;
      busy_d       = busy_q;
      ram_addr_d   = ram_addr_q;
      ram_read_d   = ram_read_q;
      ram_write_d  = ram_write_q;
      ram_wdata_d  = ram_wdata_q;
      lru_en       = 1'b0;
      lru_way      = way_q;
      fill_en      = 1'b0;
      set_dirty    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (search_cache) begin
               req_addr_d  = address;
               req_we_d    = write_en;
               req_wdata_d = write_data;
               busy_d      = 1'b1;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            lookup_hit_d = lookup_hit;
            word_d       = '0;
            if (lookup_hit) begin
               way_d   = hit_way;
               lru_en  = 1'b1;
               lru_way = hit_way;
               state_d = RESPOND;
            end else begin
               way_d = victim_way;
               if (dirty_mem[req_set][victim_way]) begin
                  ram_write_d = 1'b1;
                  ram_addr_d  = {tag_mem[{req_set, victim_way}], req_set, {OFF_W{1'b0}}};
                  ram_wdata_d = data_mem[{req_set, victim_way, {OFF_W{1'b0}}}];
                  state_d     = WRITEBACK;
               end else begin
                  ram_read_d = 1'b1;
                  ram_addr_d = {req_tag, req_set, {OFF_W{1'b0}}};
                  state_d    = REFILL;
               end
            end
         end
         WRITEBACK: begin
            if (RAM_ready) begin
               if (word_q == LAST_WORD) begin
                  ram_write_d = 1'b0;
                  ram_read_d  = 1'b1;
                  ram_addr_d  = {req_tag, req_set, {OFF_W{1'b0}}};
                  word_d      = '0;
                  state_d     = REFILL;
               end else begin
                  word_d      = word_nxt;
                  ram_addr_d  = {tag_mem[{req_set, way_q}], req_set, word_nxt};
                  ram_wdata_d = data_mem[{req_set, way_q, word_nxt}];
               end
            end
         end
         REFILL: begin
            if (RAM_ready) begin
               if (word_q == LAST_WORD) begin
                  ram_read_d = 1'b0;
                  fill_en    = 1'b1;
                  lru_en     = 1'b1;
                  state_d    = RESPOND;
               end else begin
                  word_d     = word_nxt;
                  ram_addr_d = {req_tag, req_set, word_nxt};
               end
            end
         end
         RESPOND: begin
            data_ready_d = 1'b1;
            hit_d        = lookup_hit_q;
            data_d       = req_we_q ? req_wdata_q : data_mem[{req_set, way_q, req_word}];
            set_dirty    = req_we_q;
            busy_d       = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         req_addr_q   <= '0;
         req_we_q     <= 1'b0;
         req_wdata_q  <= '0;
         lookup_hit_q <= 1'b0;
         way_q        <= '0;
         word_q       <= '0;
         hit_q        <= 1'b0;
         data_ready_q <= 1'b0;
         data_q       <= '0;
         busy_q       <= 1'b0;
         ram_addr_q   <= '0;
         ram_read_q   <= 1'b0;
         ram_write_q  <= 1'b0;
         ram_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         req_we_q     <= req_we_d;
         req_wdata_q  <= req_wdata_d;
         lookup_hit_q <= lookup_hit_d;
         way_q        <= way_d;
         word_q       <= word_d;
         hit_q        <= hit_d;
         data_ready_q <= data_ready_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
         ram_addr_q   <= ram_addr_d;
         ram_read_q   <= ram_read_d;
         ram_write_q  <= ram_write_d;
         ram_wdata_q  <= ram_wdata_d;
      end
   end

   // metadata: a line only becomes valid once its last refill word has landed
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_mem[IDX_W'(s)] <= '0;
            dirty_mem[IDX_W'(s)] <= '0;
            for (int unsigned w = 0; w < WAYS; w++) age_mem[IDX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
         end
      end else begin
         if (fill_en) begin
            valid_mem[req_set][way_q] <= 1'b1;
            dirty_mem[req_set][way_q] <= 1'b0;
         end
         if (set_dirty) dirty_mem[req_set][way_q] <= 1'b1;
         if (lru_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == lru_way)
                  age_mem[req_set][WAY_W'(w)] <= '0;
               else if (age_mem[req_set][WAY_W'(w)] < age_mem[req_set][lru_way])
                  age_mem[req_set][WAY_W'(w)] <= age_mem[req_set][WAY_W'(w)] + WAY_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (state_q == REFILL && RAM_ready)
         data_mem[{req_set, way_q, word_q}] <= main_memory_data;
      if (set_dirty)
         data_mem[{req_set, way_q, req_word}] <= req_wdata_q;
      if (fill_en)
         tag_mem[{req_set, way_q}] <= req_tag;
   end

   assign hit         = hit_q;
   assign data_ready  = data_ready_q;
   assign data        = data_q;
   assign busy        = busy_q;
   assign RAM_address = ram_addr_q;
   assign RAM_read    = ram_read_q;
   assign RAM_write   = ram_write_q;
   assign RAM_wdata   = ram_wdata_q;
endmodule
